// File: rtl/audio_echo_mc_if.sv
// Sample stream bundle for audio_echo_mc: input and output valid/ready
// channels. The master drives samples in; the slave is the echo block.
interface audio_echo_mc_if #(
    parameter int DATA_W   = 32,
    parameter int CHANNELS = 2
);
    localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [CW-1:0]     out_chan;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_chan
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_chan
    );
endinterface

// File: rtl/audio_echo_mc.sv
// Multi-channel feedback echo: per-channel circular delay line in RAM,
// output = sat(x + echo*mix), line write = sat(x + echo*fb).
module audio_echo_mc #(
    parameter int DATA_W   = 32,
    parameter int CHANNELS = 2,
    parameter int ADDR_W   = 14,
    parameter int GAIN_W   = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    audio_echo_mc_if.slave    bus,
    input  logic [ADDR_W-1:0] cfg_delay,
    input  logic [GAIN_W-1:0] cfg_mix_gain,
    input  logic [GAIN_W-1:0] cfg_fb_gain,
    input  logic              cfg_bypass
);
    localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int PW = DATA_W + GAIN_W + 1;
    localparam logic [CW-1:0] LAST = CW'(CHANNELS - 1);
    localparam logic [ADDR_W-1:0] FILL_MAX = '1;

    // RAM data returns and the result is registered in the same CALC cycle,
    // so out_valid rises three cycles after acceptance.
    typedef enum logic [1:0] {IDLE, RD, CALC, OUT} state_t;
    state_t state_q, state_d;

    logic              rdy_q, vld_q, byp_q;
    logic [DATA_W-1:0] x_q, dout_q, rdata_q;
    logic [CW-1:0]     chan_q, cur_q, ochan_q;
    logic [ADDR_W-1:0] wp_q, fill_q, dly_q;
    logic [GAIN_W-1:0] mix_q, fbg_q;
    logic [DATA_W-1:0] mem [2**(CW+ADDR_W)];

    logic                 acc, hs, wr_en, fin;
    logic [CW+ADDR_W-1:0] raddr, waddr;
    logic signed [PW-1:0] echo_w, x_w, mg_w, fg_w, pm, pf;
    logic [DATA_W-1:0]    out_v, wr_v;

    function automatic logic [DATA_W-1:0] sat(input logic signed [PW-1:0] s);
        logic signed [PW-1:0] hi;
        hi = '0;
        hi[DATA_W-2:0] = '1;
        if (s > hi) return hi[DATA_W-1:0];
        if (s < ~hi) return ~hi[DATA_W-1:0];
        return s[DATA_W-1:0];
    endfunction

    assign acc   = bus.in_valid & rdy_q;
    assign hs    = (state_q == OUT) & bus.out_ready;
    assign wr_en = (state_q == CALC) & ~byp_q;
    assign fin   = wr_en & (cur_q == LAST);
    assign raddr = {cur_q, wp_q - dly_q};
    assign waddr = {cur_q, wp_q};

    assign bus.in_ready  = rdy_q;
    assign bus.out_valid = vld_q;
    assign bus.out_data  = dout_q;
    assign bus.out_chan  = ochan_q;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (acc) state_d = RD;
            RD:   state_d = CALC;
            CALC: state_d = OUT;
            OUT:  if (bus.out_ready) state_d = IDLE;
        endcase
    end

    always_comb begin
        echo_w = '0;
        if (dly_q != '0 && fill_q >= dly_q) echo_w = PW'($signed(rdata_q));
        x_w   = PW'($signed(x_q));
        mg_w  = $signed(PW'({1'b0, mix_q}));
        fg_w  = $signed(PW'({1'b0, fbg_q}));
        pm    = (echo_w * mg_w) >>> GAIN_W;
        pf    = (echo_w * fg_w) >>> GAIN_W;
        out_v = byp_q ? x_q : sat(x_w + pm);
        wr_v  = sat(x_w + pf);
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[waddr] <= wr_v;
        if (state_q == RD) rdata_q <= mem[raddr];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            rdy_q   <= 1'b0;
            vld_q   <= 1'b0;
            byp_q   <= 1'b0;
            x_q     <= '0;
            dout_q  <= '0;
            chan_q  <= '0;
            cur_q   <= '0;
            ochan_q <= '0;
            wp_q    <= '0;
            fill_q  <= '0;
            dly_q   <= '0;
            mix_q   <= '0;
            fbg_q   <= '0;
        end else begin
            state_q <= state_d;
            rdy_q   <= (state_d == IDLE);
            if (acc) begin
                x_q    <= bus.in_data;
                cur_q  <= chan_q;
                byp_q  <= cfg_bypass;
                chan_q <= (chan_q == LAST) ? '0 : chan_q + CW'(1);
                // Settings change only on frame boundaries; a new delay
                // restarts the fill count so stale history stays muted.
                if (chan_q == '0) begin
                    dly_q <= cfg_delay;
                    mix_q <= cfg_mix_gain;
                    fbg_q <= cfg_fb_gain;
                    if (cfg_delay != dly_q) fill_q <= '0;
                end
            end
            if (state_q == CALC) begin
                dout_q  <= out_v;
                ochan_q <= cur_q;
                vld_q   <= 1'b1;
            end
            if (hs) vld_q <= 1'b0;
            if (fin) begin
                wp_q <= wp_q + ADDR_W'(1);
                if (fill_q != FILL_MAX) fill_q <= fill_q + ADDR_W'(1);
            end
        end
    end
endmodule
